// File: rtl/crc_pkg.sv
// Shared types and EPC Gen2 CRC constants for the serial CRC engine.
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_SHIFT = 2'd2
   } crc_state_e;

   localparam logic [4:0]  CRC5_POLY     = 5'h09;
   localparam logic [4:0]  CRC5_PRESET   = 5'b01001;
   localparam logic [4:0]  CRC5_XOROUT   = 5'h00;
   localparam logic [4:0]  CRC5_RESIDUE  = 5'h00;

   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
   localparam logic [15:0] CRC16_XOROUT  = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

endpackage

// File: rtl/crc_engine_if.sv
// Bit-stream and CRC result bundle between the tag datapath and crc_engine.
interface crc_engine_if #(
   parameter int WIDTH = 5
);
   logic             init;
   logic             bit_valid;
   logic             bit_in;
   logic             shift_req;
   logic [WIDTH-1:0] crc;
   logic [WIDTH-1:0] crc_tx;
   logic             crc_ok;
   logic             bit_out;
   logic             bit_out_valid;
   logic             busy;
   logic             done;

   modport master (
      output init, bit_valid, bit_in, shift_req,
      input  crc, crc_tx, crc_ok, bit_out, bit_out_valid, busy, done
   );

   modport slave (
      input  init, bit_valid, bit_in, shift_req,
      output crc, crc_tx, crc_ok, bit_out, bit_out_valid, busy, done
   );
endinterface

// File: rtl/crc_serializer.sv
// MSB-first shifter that streams a loaded CRC word to the backscatter encoder.
module crc_serializer #(
   parameter int WIDTH = 5
) (
   input  logic             crcinclk,
   input  logic             reset,
   input  logic             load,
   input  logic             abort,
   input  logic [WIDTH-1:0] load_val,
   output logic             bit_out,
   output logic             bit_out_valid,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] out_sr;
   logic [CW-1:0]    count;
   logic             active;
   logic             last;

   assign last = active && (count == CW'(WIDTH - 1));

   always_ff @(posedge crcinclk) begin
      if (!reset) begin
         out_sr <= '0;
         count  <= '0;
         active <= 1'b0;
      end else if (abort) begin
         out_sr <= '0;
         count  <= '0;
         active <= 1'b0;
      end else if (load) begin
         out_sr <= load_val;
         count  <= '0;
         active <= 1'b1;
      end else if (active) begin
         out_sr <= {out_sr[WIDTH-2:0], 1'b0};
         // saturate at WIDTH so a stale counter never wraps back into range
         if (count < CW'(WIDTH)) begin
            count <= count + 1'b1;
         end
         if (last) begin
            active <= 1'b0;
         end
      end
   end

   assign bit_out       = active & out_sr[WIDTH-1];
   assign bit_out_valid = active;
   assign done          = last;

endmodule

// File: rtl/crc_engine.sv
// Serial CRC-5 / CRC-16 generator with residue check and built-in serial output.
//
// state    | meaning
// ST_IDLE  | after reset, data bits ignored
// ST_ACCUM | absorbing one bit per bit_valid cycle
// ST_SHIFT | serialising crc ^ XOROUT, crc held
module crc_engine
   import crc_pkg::*;
#(
   parameter int               WIDTH   = 5,
   parameter logic [WIDTH-1:0] POLY    = CRC5_POLY,
   parameter logic [WIDTH-1:0] PRESET  = CRC5_PRESET,
   parameter logic [WIDTH-1:0] XOROUT  = CRC5_XOROUT,
   parameter logic [WIDTH-1:0] RESIDUE = CRC5_RESIDUE
) (
   input  logic         crcinclk,
   input  logic         reset,
   crc_engine_if.slave  bus
);

   crc_state_e       state_q, state_d;
   logic [WIDTH-1:0] crc_q, crc_d;
   logic             ser_load;
   logic             ser_abort;
   logic             ser_done;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur,
                                                  input logic             din);
      logic fb;
      fb = din ^ cur[WIDTH-1];
      return {cur[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
   endfunction

   always_ff @(posedge crcinclk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         crc_q   <= PRESET;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      ser_load  = 1'b0;
      ser_abort = 1'b0;
      if (bus.init) begin
         // a bit arriving with init belongs to the new frame
         state_d   = ST_ACCUM;
         ser_abort = 1'b1;
         crc_d     = bus.bit_valid ? lfsr_step(PRESET, bus.bit_in) : PRESET;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.shift_req) begin
                  state_d  = ST_SHIFT;
                  ser_load = 1'b1;
               end
            end
            ST_ACCUM: begin
               if (bus.shift_req) begin
                  state_d  = ST_SHIFT;
                  ser_load = 1'b1;
               end else if (bus.bit_valid) begin
                  crc_d = lfsr_step(crc_q, bus.bit_in);
               end
            end
            ST_SHIFT: begin
               if (ser_done) begin
                  state_d = ST_ACCUM;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   crc_serializer #(
      .WIDTH (WIDTH)
   ) u_ser (
      .crcinclk      (crcinclk),
      .reset         (reset),
      .load          (ser_load),
      .abort         (ser_abort),
      .load_val      (crc_q ^ XOROUT),
      .bit_out       (bus.bit_out),
      .bit_out_valid (bus.bit_out_valid),
      .done          (ser_done)
   );

   assign bus.done   = ser_done;
   assign bus.busy   = (state_q == ST_SHIFT);
   assign bus.crc    = crc_q;
   assign bus.crc_tx = crc_q ^ XOROUT;
   assign bus.crc_ok = (crc_q == RESIDUE);

endmodule
